eviction_write_buffer: RTL and testbench

- Line-granular write-back buffer between the L2 cache (upstream) and the cacheline adaptor / physical memory port (downstream).
- Absorbs dirty-line evictions from L2 so the L2 miss read reaches memory first; buffered writes drain to memory when the port is idle.
- Serves L2 read hits directly from buffered lines and coalesces repeated writes to the same line.
- Exposes an eviction write counter for the performance counters.

---
 rtl/eviction_write_buffer.sv | 180 ++++++++++++++++++
 tb/tb_eviction_write_buffer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eviction_write_buffer.sv
// Line-granular write-back buffer between L2 and the memory port: absorbs evictions,
// serves read hits from buffered lines, coalesces same-line writes and drains when idle.
module eviction_write_buffer #(
    parameter int DEPTH       = 4,
    parameter int LINE_BITS   = 256,
    parameter int OFFSET_BITS = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 l2_read,
    input  logic                 l2_write,
    input  logic [31:0]          l2_address,
    input  logic [LINE_BITS-1:0] l2_wdata,
    output logic [LINE_BITS-1:0] l2_rdata,
    output logic                 l2_resp,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [31:0]          mem_address,
    output logic [LINE_BITS-1:0] mem_wdata,
    input  logic [LINE_BITS-1:0] mem_rdata,
    input  logic                 mem_resp,
    output logic                 full,
    output logic                 empty,
    output logic [31:0]          eviction_write_counter
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;
    localparam int TAG_W = 32 - OFFSET_BITS;

    typedef enum logic [1:0] {IDLE, MEM_READ, MEM_WRITE, RESP} state_e;

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     head_q, head_d;
    logic [IDX_W-1:0]     tail_q, tail_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [DEPTH-1:0]     valid_q, valid_d;
    logic [LINE_BITS-1:0] rdata_q, rdata_d;
    logic [TAG_W-1:0]     rd_tag_q, rd_tag_d;
    logic [31:0]          evict_cnt_q, evict_cnt_d;

    logic [TAG_W-1:0]     tag_mem  [DEPTH];
    logic [LINE_BITS-1:0] data_mem [DEPTH];

    logic                 entry_we;
    logic                 tag_we;
    logic [IDX_W-1:0]     entry_idx;
    logic [TAG_W-1:0]     req_tag;
    logic                 hit;
    logic [IDX_W-1:0]     hit_idx;
    logic                 unused_offset;

    assign req_tag       = l2_address[31:OFFSET_BITS];
    assign unused_offset = ^l2_address[OFFSET_BITS-1:0];

    // Coalescing keeps tags unique among valid entries, so at most one hit.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && tag_mem[i] == req_tag) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            valid_q     <= '0;
            rdata_q     <= '0;
            rd_tag_q    <= '0;
            evict_cnt_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state_q     <= state_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            valid_q     <= valid_d;
            rdata_q     <= rdata_d;
            rd_tag_q    <= rd_tag_d;
            evict_cnt_q <= evict_cnt_d;
        end
    end

    // NOTE: line storage is deliberately not reset; valid bits gate every use of it.
    always_ff @(posedge clk) begin
        if (entry_we) data_mem[entry_idx] <= l2_wdata;
        if (tag_we)   tag_mem[entry_idx]  <= req_tag;
    end

    always_comb begin
        // NOTE: every comb output gets a default first, so no path can infer a latch.
        state_d     = state_q;
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        valid_d     = valid_q;
        rdata_d     = rdata_q;
        rd_tag_d    = rd_tag_q;
        evict_cnt_d = evict_cnt_q;
        entry_we    = 1'b0;
        tag_we      = 1'b0;
        entry_idx   = tail_q;
        case (state_q)
            IDLE: begin
                if (l2_write && hit) begin
                    entry_we  = 1'b1;
                    entry_idx = hit_idx;
                    state_d   = RESP;
                end else if (l2_write && !full) begin
                    entry_we        = 1'b1;
                    tag_we          = 1'b1;
                    valid_d[tail_q] = 1'b1;
                    tail_d          = tail_q + 1'b1;
                    count_d         = count_q + 1'b1;
                    state_d         = RESP;
                end else if (l2_write) begin
                    state_d = MEM_WRITE;
                end else if (l2_read && hit) begin
                    rdata_d = data_mem[hit_idx];
                    state_d = RESP;
                end else if (l2_read) begin
                    rd_tag_d = req_tag;
                    state_d  = MEM_READ;
                end else if (!empty) begin
                    state_d = MEM_WRITE;
                end
            end
            MEM_READ: begin
                if (mem_resp) begin
                    rdata_d = mem_rdata;
                    state_d = RESP;
                end
            end
            MEM_WRITE: begin
                if (mem_resp) begin
                    valid_d[head_q] = 1'b0;
                    head_d          = head_q + 1'b1;
                    count_d         = count_q - 1'b1;
                    evict_cnt_d     = evict_cnt_q + 32'd1;
                    state_d         = IDLE;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_address = '0;
        mem_wdata   = '0;
        l2_resp     = 1'b0;
        case (state_q)
            MEM_READ: begin
                mem_read    = 1'b1;
                mem_address = {rd_tag_q, {OFFSET_BITS{1'b0}}};
            end
            MEM_WRITE: begin
                mem_write   = 1'b1;
                mem_address = {tag_mem[head_q], {OFFSET_BITS{1'b0}}};
                mem_wdata   = data_mem[head_q];
            end
            RESP:    l2_resp = 1'b1;
            default: ;
        endcase
    end

    assign l2_rdata               = rdata_q;
    assign eviction_write_counter = evict_cnt_q;
endmodule

// File: tb/tb_eviction_write_buffer.sv
// Self-checking bench for eviction_write_buffer: directed vector table, hand-written corner
// sequences and a randomized run against a coherent-memory reference model.
module tb_eviction_write_buffer;
    logic         clk = 1'b0;
    logic         rst;
    logic         l2_read, l2_write;
    logic [31:0]  l2_address;
    logic [255:0] l2_wdata, l2_rdata;
    logic         l2_resp;
    logic         mem_read, mem_write;
    logic [31:0]  mem_address;
    logic [255:0] mem_wdata, mem_rdata;
    logic         mem_resp;
    logic         full, empty;
    logic [31:0]  eviction_write_counter;

    eviction_write_buffer dut (
        .clk(clk), .rst(rst),
        .l2_read(l2_read), .l2_write(l2_write), .l2_address(l2_address),
        .l2_wdata(l2_wdata), .l2_rdata(l2_rdata), .l2_resp(l2_resp),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
        .full(full), .empty(empty), .eviction_write_counter(eviction_write_counter)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] init_line(input logic [31:0] a);
        return {4{a, ~a}};
    endfunction

    function automatic logic [255:0] rand_line();
        logic [255:0] v;
        for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    // Downstream memory model: fixed response latency, logs every completed transfer.
    logic [255:0] mem_store [bit [31:0]];
    logic [31:0]  wr_addr_log[$];
    logic [255:0] wr_data_log[$];
    logic [31:0]  rd_addr_log[$];
    int mem_lat  = 1;
    int wait_cnt = 0;
    int excl_violations = 0;

    always @(negedge clk) begin
        mem_resp = 1'b0;
        if (mem_read && mem_write) excl_violations++;
        if (!rst && (mem_read || mem_write)) begin
            if (wait_cnt >= mem_lat) begin
                mem_resp = 1'b1;
                wait_cnt = 0;
                if (mem_write) begin
                    wr_addr_log.push_back(mem_address);
                    wr_data_log.push_back(mem_wdata);
                    mem_store[mem_address] = mem_wdata;
                end else begin
                    rd_addr_log.push_back(mem_address);
                    mem_rdata = mem_store.exists(mem_address) ? mem_store[mem_address] : init_line(mem_address);
                end
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    task automatic l2_req(input bit is_wr, input logic [31:0] addr, input logic [255:0] wdata,
                          output int lat, output logic [255:0] rdata);
        @(negedge clk);
        l2_write   = is_wr;
        l2_read    = !is_wr;
        l2_address = addr;
        l2_wdata   = wdata;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!l2_resp && lat < 400);
        rdata = l2_rdata;
        if (!l2_resp) begin
            checks++;
            failures++;
            $display("FAIL l2_resp_timeout: addr %h no response after %0d cycles", addr, lat);
        end
        l2_write = 1'b0;
        l2_read  = 1'b0;
    endtask

    task automatic wait_drained(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(empty && !mem_write && !mem_read && !l2_resp) && n < 1000);
        check(name, {255'd0, empty}, 256'd1);
    endtask

    task automatic wait_mem_write(input string name);
        int n = 0;
        while (!mem_write && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(name, {255'd0, mem_write}, 256'd1);
    endtask

    typedef struct {
        bit           is_wr;
        logic [31:0]  addr;
        logic [255:0] data;
        int           exp_lat;
        bit           chk_rdata;
        logic [255:0] exp_rdata;
        bit           exp_empty;
        bit           exp_full;
    } vec_t;

    vec_t vecs[9];
    logic [255:0] golden [bit [31:0]];

    initial begin
        int lat;
        int base;
        int rd_base;
        logic [255:0] rd;
        logic [255:0] d_a, d_b, d_c, d_d, d_e, d_f;
        logic [31:0]  drain_addr[5];
        logic [255:0] drain_data[5];

        d_a = {8{32'hAAAA_0001}}; d_b = {8{32'hBBBB_0002}}; d_c = {8{32'hCCCC_0003}};
        d_d = {8{32'hDDDD_0004}}; d_e = {8{32'hEEEE_0005}}; d_f = {8{32'hFFFF_0006}};

        rst = 1'b1; l2_read = 1'b0; l2_write = 1'b0; l2_address = '0; l2_wdata = '0;
        mem_rdata = '0; mem_resp = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_empty", {255'd0, empty}, 256'd1);
        check("rst_full", {255'd0, full}, 256'd0);
        check("rst_l2_resp", {255'd0, l2_resp}, 256'd0);
        check("rst_mem_rw", {254'd0, mem_read, mem_write}, 256'd0);
        check("rst_mem_address", {224'd0, mem_address}, 256'd0);
        check("rst_l2_rdata", l2_rdata, 256'd0);
        check("rst_counter", {224'd0, eviction_write_counter}, 256'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single eviction, then idle drain.
        mem_lat = 1;
        l2_req(1'b1, 32'h0000_1040, d_a, lat, rd);
        check("t1_lat", 256'(lat), 256'd1);
        check("t1_empty", {255'd0, empty}, 256'd0);
        check("t1_no_mem_write", {255'd0, mem_write}, 256'd0);
        wait_mem_write("t1_drain_start");
        check("t1_mem_address", {224'd0, mem_address}, {224'd0, 32'h0000_1040});
        check("t1_mem_wdata", mem_wdata, d_a);
        wait_drained("t1_drained");
        check("t1_counter", {224'd0, eviction_write_counter}, 256'd1);

        // Read hit on a buffered line with a non-zero offset.
        rd_base = rd_addr_log.size();
        l2_req(1'b1, 32'h0000_2000, d_a, lat, rd);
        l2_req(1'b0, 32'h0000_201C, '0, lat, rd);
        check("t2_lat", 256'(lat), 256'd1);
        check("t2_rdata", rd, d_a);
        check("t2_no_mem_read", 256'(rd_addr_log.size()), 256'(rd_base));
        wait_drained("t2_drained");
        check("t2_counter", {224'd0, eviction_write_counter}, 256'd2);

        // Coalescing: two writes to one line drain as a single transfer of the newer data.
        base = wr_addr_log.size();
        l2_req(1'b1, 32'h0000_3000, d_a, lat, rd);
        l2_req(1'b1, 32'h0000_3000, d_b, lat, rd);
        check("t3_lat", 256'(lat), 256'd1);
        wait_drained("t3_drained");
        check("t3_single_write", 256'(wr_addr_log.size() - base), 256'd1);
        check("t3_wdata", wr_data_log[base], d_b);
        check("t3_counter", {224'd0, eviction_write_counter}, 256'd3);

        // Back-to-back vector table: fill, hit, coalesce, overflow, miss.
        mem_lat = 2;
        vecs[0] = '{1'b1, 32'h0000_0100, d_a, 1, 1'b0, '0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 32'h0000_0200, d_b, 1, 1'b0, '0, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 32'h0000_021C, '0, 1, 1'b1, d_b, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 32'h0000_0300, d_c, 1, 1'b0, '0, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 32'h0000_0300, d_d, 1, 1'b0, '0, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 32'h0000_0400, d_e, 1, 1'b0, '0, 1'b0, 1'b1};
        vecs[6] = '{1'b0, 32'h0000_031F, '0, 1, 1'b1, d_d, 1'b0, 1'b1};
        vecs[7] = '{1'b1, 32'h0000_0500, d_f, 5, 1'b0, '0, 1'b0, 1'b1};
        vecs[8] = '{1'b0, 32'h0000_9000, '0, 4, 1'b1, init_line(32'h0000_9000), 1'b0, 1'b1};
        base = wr_addr_log.size();
        for (int i = 0; i < 9; i++) begin
            l2_req(vecs[i].is_wr, vecs[i].addr, vecs[i].data, lat, rd);
            check($sformatf("vec%0d_lat", i), 256'(lat), 256'(vecs[i].exp_lat));
            if (vecs[i].chk_rdata) check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("vec%0d_empty", i), {255'd0, empty}, {255'd0, vecs[i].exp_empty});
            check($sformatf("vec%0d_full", i), {255'd0, full}, {255'd0, vecs[i].exp_full});
        end
        wait_drained("tbl_drained");
        drain_addr = '{32'h100, 32'h200, 32'h300, 32'h400, 32'h500};
        drain_data = '{d_a, d_b, d_d, d_e, d_f};
        check("tbl_drain_count", 256'(wr_addr_log.size() - base), 256'd5);
        for (int i = 0; i < 5 && base + i < wr_addr_log.size(); i++) begin
            check($sformatf("tbl_drain%0d_addr", i), {224'd0, wr_addr_log[base+i]}, {224'd0, drain_addr[i]});
            check($sformatf("tbl_drain%0d_data", i), wr_data_log[base+i], drain_data[i]);
        end
        check("tbl_counter", {224'd0, eviction_write_counter}, 256'd8);

        // Slow read miss on an empty buffer.
        mem_lat = 10;
        rd_base = rd_addr_log.size();
        l2_req(1'b0, 32'h0000_8000, '0, lat, rd);
        check("t5_lat", 256'(lat), 256'd12);
        check("t5_rdata", rd, init_line(32'h0000_8000));
        check("t5_one_read", 256'(rd_addr_log.size() - rd_base), 256'd1);
        if (rd_addr_log.size() > rd_base)
            check("t5_mem_address", {224'd0, rd_addr_log[rd_base]}, {224'd0, 32'h0000_8000});

        // Randomized traffic on a small line set against the coherent-memory model.
        for (int i = 0; i < 300; i++) begin
            bit           is_wr;
            logic [31:0]  line;
            logic [255:0] wd;
            logic [255:0] exp;
            is_wr   = 1'($urandom_range(0, 1));
            line    = 32'h0004_0000 + 32'($urandom_range(0, 7)) * 32'd32;
            mem_lat = $urandom_range(0, 3);
            wd      = rand_line();
            exp     = golden.exists(line) ? golden[line] : init_line(line);
            l2_req(is_wr, line | 32'($urandom_range(0, 31)), wd, lat, rd);
            if (is_wr) golden[line] = wd;
            else       check($sformatf("rnd%0d_rdata", i), rd, exp);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_drained("rnd_drained");
        foreach (golden[k]) begin
            check($sformatf("rnd_mem_%h", k), mem_store.exists(k) ? mem_store[k] : 256'hx, golden[k]);
        end
        check("rnd_counter", {224'd0, eviction_write_counter}, 256'(wr_addr_log.size()));
        check("rw_exclusive", 256'(excl_violations), 256'd0);

        // Reset while a downstream write is outstanding.
        mem_lat = 20;
        l2_req(1'b1, 32'h0000_7000, d_c, lat, rd);
        wait_mem_write("t6_write_started");
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("t6_mem_write_drop", {255'd0, mem_write}, 256'd0);
        check("t6_empty", {255'd0, empty}, 256'd1);
        check("t6_counter", {224'd0, eviction_write_counter}, 256'd0);
        check("t6_idle", {253'd0, mem_read, l2_resp, full}, 256'd0);
        @(negedge clk);
        rst = 1'b0;
        mem_lat = 0;
        repeat (5) @(negedge clk);
        check("t6_no_drain_after_reset", {255'd0, mem_write}, 256'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end
endmodule
